// File: rtl/nfu_frame_assembler_pkg.sv
// Shared NFU constants and lane addressing for the stage-1 to stage-2 operand bus.
// Tree t, lane r of an operand frame lives at bit offset lane_off(t, r).
package nfu_frame_assembler_pkg;

    localparam int NFU_N   = 16;
    localparam int NFU_TN  = 16;
    localparam int ROW_W   = NFU_TN * NFU_N;
    localparam int FRAME_W = NFU_TN * NFU_TN * NFU_N;

    typedef logic bank_sel_t;

    function automatic int lane_off(input int t, input int r);
        return (t * NFU_TN + r) * NFU_N;
    endfunction

endpackage

// File: rtl/nfu_frame_bank.sv
// One Tn*Tn*N operand frame register. A row write lands in lane r of every tree and can
// zero all other lanes so that a frame started here never exposes stale operands.
module nfu_frame_bank
    import nfu_frame_assembler_pkg::*;
#(
    parameter int N  = NFU_N,
    parameter int Tn = NFU_TN
) (
    input  logic                    clk,
    input  logic                    wr_en_i,
    input  logic [$clog2(Tn)-1:0]   row_idx_i,
    input  logic                    clear_others_i,
    input  logic [Tn*N-1:0]         row_i,
    input  logic                    rows_en_i,
    input  logic [$clog2(Tn):0]     rows_i,
    output logic [Tn*Tn*N-1:0]      frame_o,
    output logic [$clog2(Tn):0]     rows_o
);

    logic [Tn*Tn*N-1:0]  frame_q, frame_d;
    logic [$clog2(Tn):0] rows_q, rows_d;

    always_comb begin
        frame_d = frame_q;
        rows_d  = rows_q;
        if (wr_en_i) begin
            for (int t = 0; t < Tn; t++) begin
                for (int r = 0; r < Tn; r++) begin
                    if (r == int'(row_idx_i)) begin
                        frame_d[(t*Tn+r)*N +: N] = row_i[t*N +: N];
                    end else if (clear_others_i) begin
                        frame_d[(t*Tn+r)*N +: N] = '0;
                    end
                end
            end
        end
        if (rows_en_i) begin
            rows_d = rows_i;
        end
    end

    // Operand storage only; visibility is gated by the owner's full flag, so no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        rows_q  <= rows_d;
    end

    assign frame_o = frame_q;
    assign rows_o  = rows_q;

endmodule

// File: rtl/nfu_frame_assembler.sv
// Transposes Tn product rows into one adder-tree operand frame, double-buffered so row
// intake continues while the previous frame waits for the cluster.
module nfu_frame_assembler
    import nfu_frame_assembler_pkg::*;
#(
    parameter int N  = NFU_N,
    parameter int Tn = NFU_TN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_row_valid,
    output logic                    o_row_ready,
    input  logic [Tn*N-1:0]         i_row,
    input  logic                    i_row_last,
    output logic                    o_frame_valid,
    input  logic                    i_frame_ready,
    output logic [Tn*Tn*N-1:0]      o_frame,
    output logic [$clog2(Tn):0]     o_frame_rows
);

    localparam int CW = $clog2(Tn);

    logic [1:0]    full_q, full_d;
    bank_sel_t     wr_bank_q, wr_bank_d;
    bank_sel_t     rd_bank_q, rd_bank_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;

    logic          row_acc, frame_close, frame_take;
    logic [CW:0]   rows_next;

    logic [Tn*Tn*N-1:0] bank_frame [2];
    logic [CW:0]        bank_rows  [2];

    // Ready depends only on registered flags, never on the downstream ready.
    assign o_row_ready   = !full_q[wr_bank_q];
    assign o_frame_valid = full_q[rd_bank_q];

    assign row_acc     = i_row_valid && o_row_ready;
    assign frame_close = row_acc && ((row_cnt_q == CW'(Tn - 1)) || i_row_last);
    assign frame_take  = o_frame_valid && i_frame_ready;
    assign rows_next   = {1'b0, row_cnt_q} + (CW+1)'(1);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        row_cnt_d = row_cnt_q;
        if (frame_close) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            row_cnt_d         = '0;
        end else if (row_acc) begin
            row_cnt_d = row_cnt_q + CW'(1);
        end
        // A full bank is never written, so close and take always hit different bits.
        if (frame_take) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            row_cnt_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        nfu_frame_bank #(
            .N  (N),
            .Tn (Tn)
        ) u_bank (
            .clk            (clk),
            .wr_en_i        (row_acc && (wr_bank_q == 1'(b))),
            .row_idx_i      (row_cnt_q),
            .clear_others_i (row_cnt_q == '0),
            .row_i          (i_row),
            .rows_en_i      (frame_close && (wr_bank_q == 1'(b))),
            .rows_i         (rows_next),
            .frame_o        (bank_frame[b]),
            .rows_o         (bank_rows[b])
        );
    end

    assign o_frame      = o_frame_valid ? bank_frame[rd_bank_q] : '0;
    assign o_frame_rows = o_frame_valid ? bank_rows[rd_bank_q]  : '0;

endmodule

// File: tb/tb_nfu_frame_assembler.sv
// Bench for nfu_frame_assembler: a frame-queue model checked every cycle plus directed
// literal expectations for transpose, short frames, back-pressure and reset.
module tb_nfu_frame_assembler;
    import nfu_frame_assembler_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                i_row_valid = 1'b0;
    logic                o_row_ready;
    logic [ROW_W-1:0]    i_row = '0;
    logic                i_row_last = 1'b0;
    logic                o_frame_valid;
    logic                i_frame_ready = 1'b0;
    logic [FRAME_W-1:0]  o_frame;
    logic [4:0]          o_frame_rows;

    nfu_frame_assembler #(.N(NFU_N), .Tn(NFU_TN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_row_valid   (i_row_valid),
        .o_row_ready   (o_row_ready),
        .i_row         (i_row),
        .i_row_last    (i_row_last),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame       (o_frame),
        .o_frame_rows  (o_frame_rows)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRAME_W-1:0] data;
        int                 rows;
    } frame_t;

    frame_t            exp_q[$];
    logic [ROW_W-1:0]  cur_rows[$];
    int n_cmp = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int both_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] get_lane(input logic [FRAME_W-1:0] f, input int t, input int r);
        return f[lane_off(t, r) +: NFU_N];
    endfunction

    task automatic chk_frame(input string name, input logic [FRAME_W-1:0] act,
                             input logic [FRAME_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < NFU_TN * NFU_TN; k++) begin
                if (get_lane(act, k / NFU_TN, k % NFU_TN) !== get_lane(exp, k / NFU_TN, k % NFU_TN)) begin
                    $display("FAIL %s: tree %0d lane %0d got %h expected %h at %0t", name,
                             k / NFU_TN, k % NFU_TN, get_lane(act, k / NFU_TN, k % NFU_TN),
                             get_lane(exp, k / NFU_TN, k % NFU_TN), $time);
                    break;
                end
            end
        end
    endtask

    // Model: completed frames wait in order; two banks means at most two outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_rows.delete();
            chk("reset_row_ready", 64'(o_row_ready), 64'd1);
            chk("reset_frame_valid", 64'(o_frame_valid), 64'd0);
            chk("reset_frame_rows", 64'(o_frame_rows), 64'd0);
            chk("reset_frame_zero", 64'(o_frame == '0), 64'd1);
        end else begin
            logic m_ready, m_valid, acc, cons, closing;
            m_ready = (exp_q.size() < 2);
            m_valid = (exp_q.size() > 0);
            chk("row_ready", 64'(o_row_ready), 64'(m_ready));
            chk("frame_valid", 64'(o_frame_valid), 64'(m_valid));
            if (m_valid) begin
                chk("frame_rows", 64'(o_frame_rows), 64'(exp_q[0].rows));
                chk_frame("frame_data", o_frame, exp_q[0].data);
            end else begin
                chk("idle_rows", 64'(o_frame_rows), 64'd0);
                chk("idle_frame_zero", 64'(o_frame == '0), 64'd1);
            end
            if (i_row_valid && !o_row_ready) stall_cnt++;
            acc     = i_row_valid && m_ready;
            cons    = m_valid && i_frame_ready;
            closing = acc && ((cur_rows.size() + 1 == NFU_TN) || i_row_last);
            if (closing && cons) both_cnt++;
            if (cons) void'(exp_q.pop_front());
            if (acc) begin
                cur_rows.push_back(i_row);
                if (closing) begin
                    frame_t f;
                    f.data = '0;
                    foreach (cur_rows[r]) begin
                        for (int t = 0; t < NFU_TN; t++) begin
                            f.data[lane_off(t, r) +: NFU_N] = cur_rows[r][t*NFU_N +: NFU_N];
                        end
                    end
                    f.rows = cur_rows.size();
                    exp_q.push_back(f);
                    cur_rows.delete();
                end
            end
        end
    end

    function automatic logic [ROW_W-1:0] mkrow(input int k);
        logic [ROW_W-1:0] row;
        for (int t = 0; t < NFU_TN; t++) begin
            row[t*NFU_N +: NFU_N] = {8'(k), 8'(t)};
        end
        return row;
    endfunction

    function automatic logic [ROW_W-1:0] rndrow();
        logic [ROW_W-1:0] row;
        for (int j = 0; j < ROW_W / 32; j++) row[j*32 +: 32] = $urandom;
        return row;
    endfunction

    // Called and returning at posedge+1; holds the row until the DUT takes it.
    task automatic put_row(input logic [ROW_W-1:0] row, input logic last);
        logic rdy;
        int   guard;
        guard = 0;
        i_row_valid = 1'b1;
        i_row       = row;
        i_row_last  = last;
        forever begin
            @(negedge clk);
            rdy = o_row_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                chk("put_row_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic idle();
        i_row_valid = 1'b0;
        i_row_last  = 1'b0;
    endtask

    initial begin
        int k, bad, s0, b0, acc, cyc, wait_cyc;
        logic rdy;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_ready", 64'(o_row_ready), 64'd1);
        chk("t1_valid", 64'(o_frame_valid), 64'd0);
        chk("t1_rows", 64'(o_frame_rows), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 16-row transpose
        i_frame_ready = 1'b1;
        for (int r = 0; r < 16; r++) put_row(mkrow(r), 1'b0);
        idle();
        @(negedge clk);
        chk("t2_valid", 64'(o_frame_valid), 64'd1);
        chk("t2_rows", 64'(o_frame_rows), 64'd16);
        chk("t2_lane_3_5", 64'(get_lane(o_frame, 3, 5)), 64'h0503);
        chk("t2_lane_15_15", 64'(get_lane(o_frame, 15, 15)), 64'h0F0F);
        bad = 0;
        for (int t = 0; t < 16; t++)
            for (int r = 0; r < 16; r++)
                if (get_lane(o_frame, t, r) !== {8'(r), 8'(t)}) bad++;
        chk("t2_all_lanes_bad", 64'(bad), 64'd0);
        @(posedge clk);
        #1;

        // Short frames, landing once in each bank
        for (int rep = 0; rep < 2; rep++) begin
            i_frame_ready = 1'b0;
            for (int r = 0; r < 3; r++) put_row({ROW_W{1'b1}}, r == 2);
            idle();
            @(negedge clk);
            chk("t3_rows", 64'(o_frame_rows), 64'd3);
            chk("t3_lane_5_2", 64'(get_lane(o_frame, 5, 2)), 64'hFFFF);
            chk("t3_lane_5_3", 64'(get_lane(o_frame, 5, 3)), 64'h0000);
            chk("t3_lane_0_15", 64'(get_lane(o_frame, 0, 15)), 64'h0000);
            @(posedge clk);
            #1;
            i_frame_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        // Back-pressure: both banks fill, intake stops
        i_frame_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            i_row_valid = 1'b1;
            i_row       = mkrow(k);
            i_row_last  = 1'b0;
            @(negedge clk);
            rdy = o_row_ready;
            @(posedge clk);
            #1;
            if (rdy) k++;
        end
        chk("t4_accepted", 64'(k), 64'd32);
        chk("t4_ready_low", 64'(o_row_ready), 64'd0);
        i_frame_ready = 1'b1;
        @(negedge clk);
        chk("t4_f0_rows", 64'(o_frame_rows), 64'd16);
        chk("t4_f0_lane_2_3", 64'(get_lane(o_frame, 2, 3)), 64'h0302);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_f1_lane_2_3", 64'(get_lane(o_frame, 2, 3)), 64'h1302);
        chk("t4_ready_back", 64'(o_row_ready), 64'd1);
        for (int r = 32; r < 48; r++) put_row(mkrow(r), 1'b0);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset with one full and one partial frame held
        i_frame_ready = 1'b0;
        for (int r = 0; r < 20; r++) put_row(mkrow(r), 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("t1b_ready", 64'(o_row_ready), 64'd1);
        chk("t1b_valid", 64'(o_frame_valid), 64'd0);
        chk("t1b_rows", 64'(o_frame_rows), 64'd0);
        chk("t1b_frame_zero", 64'(o_frame == '0), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sustained throughput, then one-row frames for close/take overlap
        i_frame_ready = 1'b1;
        s0 = stall_cnt;
        for (int f = 0; f < 64; f++)
            for (int r = 0; r < 16; r++) put_row(rndrow(), 1'b0);
        idle();
        chk("t5_stalls", 64'(stall_cnt - s0), 64'd0);
        b0 = both_cnt;
        for (int f = 0; f < 8; f++) put_row(rndrow(), 1'b1);
        idle();
        chk("t5_close_and_take", 64'(both_cnt > b0), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Random handshakes
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            i_row_valid   = 1'($urandom_range(0, 1));
            i_row         = rndrow();
            i_row_last    = ($urandom_range(0, 7) == 0);
            i_frame_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = o_row_ready;
            @(posedge clk);
            #1;
            if (i_row_valid && rdy) acc++;
            cyc++;
        end
        chk("t6_rows_accepted", 64'(acc), 64'd10000);
        idle();
        i_frame_ready = 1'b1;
        wait_cyc = 0;
        while (o_frame_valid && wait_cyc < 10) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        chk("t6_drained", 64'(o_frame_valid), 64'd0);
        @(negedge clk);
        chk("t6_model_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
